// File: rtl/multi_button_pkg.sv
// multi_button_pkg: shared types, default parameter values and a width helper
// for the front-panel button controller.
//   key_state_e : per-key FSM state (IDLE / HELD / REPEAT)
//   DEF_*       : default parameter values for the controller
//   cnt_width() : bits needed to hold a counter value 0..max_val
package multi_button_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE   = 2'd0,
        KEY_HELD   = 2'd1,
        KEY_REPEAT = 2'd2
    } key_state_e;

    localparam int DEF_NUM_KEYS      = 4;
    localparam int DEF_NUM_SW        = 3;
    localparam int DEF_DBNC_CYCLES   = 65535;
    localparam int DEF_REPEAT_EN     = 1;
    localparam int DEF_REPEAT_DELAY  = 25_000_000;
    localparam int DEF_REPEAT_PERIOD = 5_000_000;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/multi_button_if.sv
// multi_button_if: pin-side inputs and terminal-side outputs of the controller.
//   KEY, SW            : raw board pins (KEY active low)
//   CleanSWOut         : debounced switch levels
//   KEY_Reg / CMD_Reg  : held state per bank, active high
//   KEY_En / CMD_En    : press / repeat strobes per bank
//   key_state, key_mode: per-key FSM state and latched bank, for observation
// Handshake: KEY_En/CMD_En are single-cycle strobes with no ready/backpressure;
// the consumer must sample them every cycle. Reg outputs are levels.
interface multi_button_if #(
    parameter int NUM_KEYS = 4,
    parameter int NUM_SW   = 3
);
    logic [NUM_KEYS-1:0]      KEY;
    logic [NUM_SW-1:0]        SW;
    logic [NUM_SW-1:0]        CleanSWOut;
    logic [NUM_KEYS-1:0]      KEY_Reg;
    logic [NUM_KEYS-1:0]      CMD_Reg;
    logic [NUM_KEYS-1:0]      KEY_En;
    logic [NUM_KEYS-1:0]      CMD_En;
    logic [NUM_KEYS-1:0][1:0] key_state;
    logic [NUM_KEYS-1:0]      key_mode;

    modport master (
        output KEY, SW,
        input  CleanSWOut, KEY_Reg, CMD_Reg, KEY_En, CMD_En, key_state, key_mode
    );

    modport slave (
        input  KEY, SW,
        output CleanSWOut, KEY_Reg, CMD_Reg, KEY_En, CMD_En, key_state, key_mode
    );
endinterface

// File: rtl/key_channel.sv
// key_channel: one push-button: synchroniser, debouncer, press/repeat FSM,
// repeat timer and bank latch.
//   clk, rst_n       : clock, async active-low reset
//   key_n            : raw button pin, active low
//   mode_sw          : debounced mode switch (1 = CMD bank, 0 = KEY bank)
//   mode             : bank latched at press-accept
//   key_reg, cmd_reg : held state on the selected bank
//   key_en, cmd_en   : one-cycle press / repeat strobe on the selected bank
//   state            : FSM state
module key_channel
    import multi_button_pkg::*;
#(
    parameter int DBNC_CYCLES   = DEF_DBNC_CYCLES,
    parameter int REPEAT_EN     = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    input  logic       mode_sw,
    output logic       mode,
    output logic       key_reg,
    output logic       cmd_reg,
    output logic       key_en,
    output logic       cmd_en,
    output key_state_e state
);
    localparam int TW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

    logic          level_n;
    logic          pressed;
    logic [TW-1:0] timer;

    // Reset level 1 = released, so a key held through reset is re-accepted
    // after a full debounce window.
    sync_debounce #(
        .DBNC_CYCLES (DBNC_CYCLES),
        .RESET_LEVEL (1'b1)
    ) u_dbnc (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (key_n),
        .level (level_n)
    );

    assign pressed = ~level_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= KEY_IDLE;
            timer   <= '0;
            mode    <= 1'b0;
            key_reg <= 1'b0;
            cmd_reg <= 1'b0;
            key_en  <= 1'b0;
            cmd_en  <= 1'b0;
        end else begin
            key_en <= 1'b0;
            cmd_en <= 1'b0;
            case (state)
                KEY_IDLE: begin
                    if (pressed) begin
                        // Bank is frozen here so a later switch flip cannot
                        // move a held key between banks.
                        state   <= KEY_HELD;
                        mode    <= mode_sw;
                        timer   <= TW'(REPEAT_DELAY);
                        key_reg <= ~mode_sw;
                        cmd_reg <= mode_sw;
                        key_en  <= ~mode_sw;
                        cmd_en  <= mode_sw;
                    end
                end
                KEY_HELD, KEY_REPEAT: begin
                    if (!pressed) begin
                        state   <= KEY_IDLE;
                        mode    <= 1'b0;
                        timer   <= '0;
                        key_reg <= 1'b0;
                        cmd_reg <= 1'b0;
                    end else if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else if (REPEAT_EN != 0) begin
                        state  <= KEY_REPEAT;
                        timer  <= TW'(REPEAT_PERIOD);
                        key_en <= ~mode;
                        cmd_en <= mode;
                    end
                end
                default: state <= KEY_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: 2-FF synchroniser followed by a debouncer.
//   clk, rst_n : clock, async active-low reset
//   raw        : asynchronous input pin
//   level      : accepted (debounced) level, RESET_LEVEL while in reset
// The accepted level flips only after DBNC_CYCLES consecutive cycles in which
// the synchronised level differs from it; any agreeing cycle clears the count.
module sync_debounce
    import multi_button_pkg::*;
#(
    parameter int   DBNC_CYCLES = DEF_DBNC_CYCLES,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam int CW = cnt_width(DBNC_CYCLES);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= RESET_LEVEL;
            sync_2 <= RESET_LEVEL;
            level  <= RESET_LEVEL;
            cnt    <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DBNC_CYCLES - 1)) begin
                // This cycle is the DBNC_CYCLES-th differing sample.
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/multi_button_controller.sv
// multi_button_controller: front-panel input controller.
//   CLOCK_50 : system clock
//   RESET_N  : async active-low reset
//   bus      : pins in (KEY, SW) and terminal-side outputs (CleanSWOut,
//              KEY_Reg, CMD_Reg, KEY_En, CMD_En, plus FSM state / bank)
// One key_channel per key; switches share only the synchroniser/debouncer.
// SW[0] (debounced) selects the bank a key is routed to at press time.
module multi_button_controller
    import multi_button_pkg::*;
#(
    parameter int NUM_KEYS      = DEF_NUM_KEYS,
    parameter int NUM_SW        = DEF_NUM_SW,
    parameter int DBNC_CYCLES   = DEF_DBNC_CYCLES,
    parameter int REPEAT_EN     = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input logic           CLOCK_50,
    input logic           RESET_N,
    multi_button_if.slave bus
);
    logic [NUM_SW-1:0]   clean_sw;
    logic [NUM_KEYS-1:0] mode;
    logic [NUM_KEYS-1:0] key_reg;
    logic [NUM_KEYS-1:0] cmd_reg;
    logic [NUM_KEYS-1:0] key_en;
    logic [NUM_KEYS-1:0] cmd_en;
    key_state_e          state [NUM_KEYS];

    for (genvar s = 0; s < NUM_SW; s++) begin : g_sw
        sync_debounce #(
            .DBNC_CYCLES (DBNC_CYCLES),
            .RESET_LEVEL (1'b0)
        ) u_sw (
            .clk   (CLOCK_50),
            .rst_n (RESET_N),
            .raw   (bus.SW[s]),
            .level (clean_sw[s])
        );
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_channel #(
            .DBNC_CYCLES   (DBNC_CYCLES),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_key (
            .clk     (CLOCK_50),
            .rst_n   (RESET_N),
            .key_n   (bus.KEY[i]),
            .mode_sw (clean_sw[0]),
            .mode    (mode[i]),
            .key_reg (key_reg[i]),
            .cmd_reg (cmd_reg[i]),
            .key_en  (key_en[i]),
            .cmd_en  (cmd_en[i]),
            .state   (state[i])
        );
        assign bus.key_state[i] = state[i];
    end

    assign bus.CleanSWOut = clean_sw;
    assign bus.KEY_Reg    = key_reg;
    assign bus.CMD_Reg    = cmd_reg;
    assign bus.KEY_En     = key_en;
    assign bus.CMD_En     = cmd_en;
    assign bus.key_mode   = mode;
endmodule
